// File: rtl/truth_table_checker_pkg.sv
// Shared types and helpers for the truth-table sweep checker.
package truth_table_checker_pkg;

   // Sweep sequencer states.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_CHECK  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   // Width of the settle countdown; covers settle times up to 15 cycles.
   localparam int unsigned SETTLE_W = 4;

   // Number of input vectors in an exhaustive sweep of an n_in-bit input.
   function automatic int unsigned num_vectors(input int unsigned n_in);
      return 32'd1 << n_in;
   endfunction

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Settle countdown: loaded with the wait length, counts down to zero.
// expired is high in the last wait cycle, so the owner leaves its wait
// state after exactly 'value' cycles.
module settle_timer
   import truth_table_checker_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [SETTLE_W-1:0] value,
   output logic                expired
);

   logic [SETTLE_W-1:0] cnt;

   // Down-counter with load priority; parks at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= value;
      end else if (cnt != '0) begin
         cnt <= cnt - SETTLE_W'(1);
      end
   end

   assign expired = (cnt == SETTLE_W'(1));

endmodule

// File: rtl/truth_table_checker.sv
// Exhaustive truth-table checker for an external combinational block.
// Drives every input vector in ascending order, waits SETTLE cycles,
// compares the response with the latched expected table and reports
// mismatch count and lowest failing vector.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no sweep since reset; waiting for start
// S_SETTLE | vector idx driven on dut_in, waiting for the DUT to settle
// S_CHECK  | one cycle: compare dut_out with expected entry idx
// S_DONE   | sweep finished; results held, start accepted again
module truth_table_checker
   import truth_table_checker_pkg::*;
#(
   parameter int N_IN   = 4,
   parameter int N_OUT  = 1,
   parameter int SETTLE = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       stop_on_fail,
   input  logic [N_OUT*(2**N_IN)-1:0] exp_table,
   output logic [N_IN-1:0]            dut_in,
   input  logic [N_OUT-1:0]           dut_out,
   output logic                       busy,
   output logic                       done,
   output logic                       pass,
   output logic [N_IN:0]              err_count,
   output logic [N_IN-1:0]            first_fail
);

   localparam int N_VEC = int'(num_vectors(N_IN));
   localparam int TBL_W = N_OUT * N_VEC;
   localparam int CW    = N_IN + 1;
   localparam logic [N_IN-1:0] LAST_IDX = N_IN'(N_VEC - 1);

   state_t            state;
   logic [TBL_W-1:0]  tbl_q;
   logic              stop_q;
   logic [N_IN-1:0]   idx;

   logic [N_OUT-1:0]  exp_entry;
   logic              accept;
   logic              mismatch;
   logic              last_vec;
   logic              finish;
   logic              timer_load;
   logic              timer_expired;

   // Sweep decisions derived from the current state and DUT response.
   always_comb begin
      exp_entry  = tbl_q[int'(idx)*N_OUT +: N_OUT];
      accept     = start && ((state == S_IDLE) || (state == S_DONE));
      mismatch   = (state == S_CHECK) && (dut_out != exp_entry);
      last_vec   = (idx == LAST_IDX);
      finish     = (mismatch && stop_q) || last_vec;
      timer_load = accept || ((state == S_CHECK) && !finish);
   end

   settle_timer u_settle_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (timer_load),
      .value   (SETTLE_W'(SETTLE)),
      .expired (timer_expired)
   );

   // Sweep sequencer with registered status outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         tbl_q      <= '0;
         stop_q     <= 1'b0;
         idx        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         first_fail <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  tbl_q      <= exp_table;
                  stop_q     <= stop_on_fail;
                  err_count  <= '0;
                  first_fail <= '0;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  idx        <= '0;
                  busy       <= 1'b1;
                  state      <= S_SETTLE;
               end
            end
            S_SETTLE: begin
               if (timer_expired) begin
                  state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (mismatch) begin
                  err_count <= err_count + CW'(1);
                  // Only the lowest failing vector is recorded.
                  if (err_count == '0) begin
                     first_fail <= idx;
                  end
               end
               if (finish) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= !mismatch && (err_count == '0);
                  state <= S_DONE;
               end else begin
                  idx   <= idx + N_IN'(1);
                  state <= S_SETTLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // The vector index register drives the DUT directly, so dut_in holds
   // its last value through S_DONE.
   assign dut_in = idx;

endmodule
